// File: rtl/cram_pkg.sv
// Shared definitions for the CellularRAM burst responder: FSM state encoding,
// BCR field positions, latency clamp and burst-length decode.
package cram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_BURST = 2'd2
    } cram_state_t;

    localparam int BCR_LAT_MSB  = 13;
    localparam int BCR_LAT_LSB  = 11;
    localparam int BCR_WRAP_BIT = 3;
    localparam int BCR_LEN_MSB  = 2;
    localparam int BCR_LEN_LSB  = 0;

    localparam logic [2:0] LAT_MIN   = 3'd2;
    localparam logic [2:0] LAT_MAX   = 3'd6;
    localparam logic [2:0] LAT_CLAMP = 3'd3;

    // log2 of the fixed burst length; 0 means continuous
    function automatic logic [2:0] burst_len_log2(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // illegal latency codes fall back to the clamp value
    function automatic logic [2:0] latency_decode(input logic [2:0] code);
        if (code < LAT_MIN || code > LAT_MAX)
            return LAT_CLAMP;
        return code;
    endfunction

endpackage

// File: rtl/cram_burst_addr_gen.sv
// Loadable burst address counter: tracks beat number, produces the next
// address (optionally wrapping inside the burst-aligned block) and flags
// the final beat of a fixed-length burst.
module cram_burst_addr_gen
    import cram_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          ResetCount,
    input  logic          load,
    input  logic [AW-1:0] start_addr,
    input  logic          advance,
    input  logic [2:0]    len_code,
    input  logic          wrap_en,
    output logic [AW-1:0] addr,
    output logic [AW-1:0] addr_next,
    output logic          last
);

    logic [3:0]    beat;
    logic [3:0]    beat_max;
    logic [AW-1:0] inc_mask;
    logic [AW-1:0] addr_inc;

    // highest beat index of a fixed burst; 0 marks continuous mode
    always_comb begin
        beat_max = 4'd0;
        case (burst_len_log2(len_code))
            3'd2:    beat_max = 4'd3;
            3'd3:    beat_max = 4'd7;
            3'd4:    beat_max = 4'd15;
            default: beat_max = 4'd0;
        endcase
    end

    // when wrapping only the low log2(N) bits take the incremented value
    assign inc_mask  = (wrap_en && beat_max != 4'd0) ? AW'(beat_max) : '1;
    assign addr_inc  = addr + AW'(1);
    assign addr_next = (addr & ~inc_mask) | (addr_inc & inc_mask);
    assign last      = (beat_max != 4'd0) && (beat == beat_max);

    // address/beat register: load on a new access, step once per data beat
    always_ff @(posedge CLK or posedge ResetCount) begin
        if (ResetCount) begin
            addr <= '0;
            beat <= 4'd0;
        end else if (load) begin
            addr <= start_addr;
            beat <= 4'd0;
        end else if (advance) begin
            addr <= addr_next;
            beat <= beat + 4'd1;
        end
    end

endmodule

// File: rtl/cellular_ram_burst_responder.sv
// CellularRAM synchronous burst responder (slave side of the PSRAM bus).
// Loads the BCR on config writes and serves variable-latency read/write bursts
// from an internal word array.
// Build option: define CRAM_RESP_WRAP_EN to honour BCR[3] burst wrapping;
// without it BCR[3] is stored but addresses always increment linearly.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for CE#/ADV#; config writes load the BCR here
// ST_LAT   | initial latency, WAIT asserted, counter running down
// ST_BURST | one data beat per edge until last beat or CE# high
module cellular_ram_burst_responder
    import cram_pkg::*;
#(
    parameter int          MEM_AW    = 8,
    parameter logic [15:0] BCR_RESET = 16'h980F
) (
    input  logic        CLK,
    input  logic        ResetCount,
    input  logic        ConCE,
    input  logic        ConADV,
    input  logic        ConWE,
    input  logic        ConOE,
    input  logic        ConCRE,
    input  logic        ConLB,
    input  logic        ConUB,
    input  logic [19:0] AddrIn,
    input  logic [15:0] DqIn,
    output logic [15:0] DqOut,
    output logic        DqOe,
    output logic        ConWait,
    output logic [15:0] Bcr
);

    cram_state_t       state;
    logic              dir_write;
    logic [2:0]        lat_cnt;
    logic [2:0]        lat_l;
    logic [15:0]       mem [2**MEM_AW];
    logic              access;
    logic              start;
    logic              beat_step;
    logic              mem_we;
    logic              wrap_active;
    logic              last;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] addr_next;

    assign access    = !ConCE && !ConADV;
    assign start     = access && !ConCRE;
    assign beat_step = (state == ST_BURST) && !ConCE && ConADV;
    assign mem_we    = beat_step && dir_write && !ConWE;
    assign lat_l     = latency_decode(Bcr[BCR_LAT_MSB:BCR_LAT_LSB]);

`ifdef CRAM_RESP_WRAP_EN
    assign wrap_active = ~Bcr[BCR_WRAP_BIT];
`else
    assign wrap_active = 1'b0;
`endif

    cram_burst_addr_gen #(
        .AW (MEM_AW)
    ) u_addr_gen (
        .CLK        (CLK),
        .ResetCount (ResetCount),
        .load       (start),
        .start_addr (AddrIn[MEM_AW-1:0]),
        .advance    (beat_step),
        .len_code   (Bcr[BCR_LEN_MSB:BCR_LEN_LSB]),
        .wrap_en    (wrap_active),
        .addr       (addr),
        .addr_next  (addr_next),
        .last       (last)
    );

    // byte-gated write beats; the array is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            if (!ConLB) mem[addr][7:0]  <= DqIn[7:0];
            if (!ConUB) mem[addr][15:8] <= DqIn[15:8];
        end
    end

    // access FSM with registered WAIT, read data and drive enable
    always_ff @(posedge CLK or posedge ResetCount) begin
        if (ResetCount) begin
            state     <= ST_IDLE;
            dir_write <= 1'b0;
            lat_cnt   <= 3'd0;
            ConWait   <= 1'b0;
            DqOut     <= 16'h0000;
            DqOe      <= 1'b0;
            Bcr       <= BCR_RESET;
        end else if (ConCE) begin
            state   <= ST_IDLE;
            ConWait <= 1'b0;
            DqOe    <= 1'b0;
        end else if (access) begin
            // any ADV# strobe restarts from the idle rules, aborting a burst
            DqOe <= 1'b0;
            if (ConCRE) begin
                if (!ConWE) Bcr <= AddrIn[15:0];
                state   <= ST_IDLE;
                ConWait <= 1'b0;
            end else begin
                dir_write <= !ConWE;
                lat_cnt   <= lat_l - 3'd1;
                state     <= ST_LAT;
                ConWait   <= 1'b1;
            end
        end else begin
            case (state)
                ST_LAT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        state   <= ST_BURST;
                        ConWait <= 1'b0;
                        if (!dir_write) begin
                            DqOut <= mem[addr];
                            DqOe  <= !ConOE;
                        end
                    end
                end
                ST_BURST: begin
                    ConWait <= 1'b0;
                    if (last) begin
                        state <= ST_IDLE;
                        DqOe  <= 1'b0;
                    end else if (!dir_write) begin
                        DqOut <= mem[addr_next];
                        DqOe  <= !ConOE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ConWait <= 1'b0;
                    DqOe    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cellular_ram_burst_responder.sv
// Directed bench for the CellularRAM burst responder: BCR load, fixed and
// continuous bursts, byte lanes, reset during latency and (with
// CRAM_RESP_WRAP_EN) wrapped bursts.
module tb_cellular_ram_burst_responder;

    logic        clk = 1'b0;
    logic        reset_count = 1'b1;
    logic        con_ce, con_adv, con_we, con_oe, con_cre, con_lb, con_ub;
    logic [19:0] addr_in;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        con_wait;
    logic [15:0] bcr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cellular_ram_burst_responder dut (
        .CLK        (clk),
        .ResetCount (reset_count),
        .ConCE      (con_ce),
        .ConADV     (con_adv),
        .ConWE      (con_we),
        .ConOE      (con_oe),
        .ConCRE     (con_cre),
        .ConLB      (con_lb),
        .ConUB      (con_ub),
        .AddrIn     (addr_in),
        .DqIn       (dq_in),
        .DqOut      (dq_out),
        .DqOe       (dq_oe),
        .ConWait    (con_wait),
        .Bcr        (bcr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        con_ce  = 1'b1;
        con_adv = 1'b1;
        con_we  = 1'b1;
        con_oe  = 1'b1;
        con_cre = 1'b0;
        con_lb  = 1'b0;
        con_ub  = 1'b0;
        addr_in = 20'h0;
        dq_in   = 16'h0;
    endtask

    task automatic cfg(input logic [15:0] value);
        @(negedge clk);
        con_ce  = 1'b0;
        con_adv = 1'b0;
        con_cre = 1'b1;
        con_we  = 1'b0;
        addr_in = {4'h0, value};
        @(negedge clk);
        bus_idle();
        check_eq("bcr_load", bcr, value);
    endtask

    // words[16*i +: 16] is beat i
    task automatic wr_burst(input logic [19:0] a, input int lat, input logic [63:0] words,
                            input logic ub, input logic lb, input string tag);
        @(negedge clk);
        con_ce  = 1'b0;
        con_adv = 1'b0;
        con_cre = 1'b0;
        con_we  = 1'b0;
        con_ub  = ub;
        con_lb  = lb;
        addr_in = a;
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            con_adv = 1'b1;
            check_eq({tag, "_wait_hi"}, con_wait, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            con_adv = 1'b1;
            check_eq({tag, "_wait_lo"}, con_wait, 1'b0);
            dq_in = words[16*i +: 16];
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd_burst(input logic [19:0] a, input int lat, input int n,
                            input logic [63:0] words, input bit cont, input string tag);
        @(negedge clk);
        con_ce  = 1'b0;
        con_adv = 1'b0;
        con_cre = 1'b0;
        con_we  = 1'b1;
        con_oe  = 1'b0;
        addr_in = a;
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            con_adv = 1'b1;
            check_eq({tag, "_wait_hi"}, con_wait, 1'b1);
            check_eq({tag, "_oe_lat"}, dq_oe, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            con_adv = 1'b1;
            check_eq({tag, "_data"}, dq_out, words[16*i +: 16]);
            check_eq({tag, "_oe_beat"}, dq_oe, 1'b1);
            check_eq({tag, "_wait_lo"}, con_wait, 1'b0);
            if (cont && i == n - 1) con_ce = 1'b1;
        end
        @(negedge clk);
        check_eq({tag, "_oe_end"}, dq_oe, 1'b0);
        check_eq({tag, "_wait_end"}, con_wait, 1'b0);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        reset_count = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_wait", con_wait, 1'b0);
        check_eq("rst_oe", dq_oe, 1'b0);
        check_eq("rst_dout", dq_out, 16'h0000);
        check_eq("rst_bcr", bcr, 16'h980F);
        reset_count = 1'b0;
        @(negedge clk);

        // latency 2, no-wrap, length 4
        cfg(16'h9009);
        wr_burst(20'h00010, 2, 64'hA3A3_A2A2_A1A1_A0A0, 1'b0, 1'b0, "wr10");
        rd_burst(20'h00010, 2, 4, 64'hA3A3_A2A2_A1A1_A0A0, 1'b0, "rd10");
        wr_burst(20'h00020, 2, 64'hC3C3_C2C2_C1C1_C0C0, 1'b0, 1'b0, "wr20");

        // continuous read, CE# raised after three beats
        cfg(16'h900F);
        rd_burst(20'h00020, 2, 3, 64'h0000_C2C2_C1C1_C0C0, 1'b1, "cont20");

        // byte lanes: upper byte masked on the second write
        cfg(16'h9009);
        wr_burst(20'h00030, 2, 64'h4444_3333_2222_1234, 1'b0, 1'b0, "wr30");
        wr_burst(20'h00030, 2, 64'hBEEF_BEEF_BEEF_BEEF, 1'b1, 1'b0, "wr30_lb");
        rd_burst(20'h00030, 2, 4, 64'h44EF_33EF_22EF_12EF, 1'b0, "rd30");

`ifdef CRAM_RESP_WRAP_EN
        // length 4 with wrap, start mid-block
        cfg(16'h9001);
        wr_burst(20'h0000C, 2, 64'hD3D3_D2D2_D1D1_D0D0, 1'b0, 1'b0, "wr0c");
        rd_burst(20'h0000E, 2, 4, 64'hD1D1_D0D0_D3D3_D2D2, 1'b0, "wrap0e");
        cfg(16'h9009);
`endif

        // reset pulse while WAIT is high
        @(negedge clk);
        con_ce  = 1'b0;
        con_adv = 1'b0;
        con_cre = 1'b0;
        con_we  = 1'b1;
        con_oe  = 1'b0;
        addr_in = 20'h00010;
        @(negedge clk);
        con_adv = 1'b1;
        check_eq("lat_wait_pre_rst", con_wait, 1'b1);
        reset_count = 1'b1;
        #1;
        check_eq("rst_mid_wait", con_wait, 1'b0);
        check_eq("rst_mid_oe", dq_oe, 1'b0);
        check_eq("rst_mid_bcr", bcr, 16'h980F);
        @(negedge clk);
        reset_count = 1'b0;
        bus_idle();

        // reset BCR: latency 3, continuous; array contents survive reset
        rd_burst(20'h00010, 3, 2, 64'h0000_0000_A1A1_A0A0, 1'b1, "post_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
